// File: rtl/table_port_arbiter_if.sv
// Table memory port bundle: the arbiter drives the request side (src),
// the memory drives read_data back (sink).
interface memory_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 64
);
    logic              enable;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport src  (output enable, wr_en, addr, write_data, input  read_data);
    modport sink (input  enable, wr_en, addr, write_data, output read_data);
endinterface

// File: rtl/table_port_arbiter.sv
// Two-requester arbiter in front of a single-port table memory: alternating
// priority, lock reserves the table for requester 0, responses two cycles after grant.
module table_port_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 10
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              rq0_valid,
    output logic              rq0_ready,
    input  logic              rq0_we,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_wdata,

    input  logic              rq1_valid,
    output logic              rq1_ready,
    input  logic              rq1_we,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_wdata,

    output logic              rs0_valid,
    output logic              rs0_err,
    output logic [DATA_W-1:0] rs0_rdata,

    output logic              rs1_valid,
    output logic              rs1_err,
    output logic [DATA_W-1:0] rs1_rdata,

    memory_if.src             tbl,

    input  logic              lock,
    output logic [15:0]       conflict_cnt
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic              ptr;
    logic              gnt0;
    logic              gnt1;
    logic              gnt_any;
    logic              gnt_we;
    logic              gnt_err;
    logic              gnt_fwd;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;

    logic              s1_valid, s1_id, s1_we, s1_err;
    logic              s2_valid, s2_id, s2_we, s2_err;

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        gnt0 = rst_n & rq0_valid & (~rq1_valid | lock | ~ptr);
        gnt1 = rst_n & rq1_valid & ~lock & (~rq0_valid | ptr);
    end

    assign gnt_any   = gnt0 | gnt1;
    assign gnt_we    = gnt1 ? rq1_we    : rq0_we;
    assign gnt_addr  = gnt1 ? rq1_addr  : rq0_addr;
    assign gnt_wdata = gnt1 ? rq1_wdata : rq0_wdata;
    assign gnt_err   = ({1'b0, gnt_addr} >= DEPTH_L);
    assign gnt_fwd   = gnt_any & ~gnt_err;

    assign rq0_ready = gnt0;
    assign rq1_ready = gnt1;

    // After a grant the other requester wins the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (gnt_any) begin
            ptr <= ~gnt1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_id    <= 1'b0;
            s1_we    <= 1'b0;
            s1_err   <= 1'b0;
            s2_valid <= 1'b0;
            s2_id    <= 1'b0;
            s2_we    <= 1'b0;
            s2_err   <= 1'b0;
        end else begin
            s1_valid <= gnt_any;
            s1_id    <= gnt1;
            s1_we    <= gnt_any & gnt_we;
            s1_err   <= gnt_any & gnt_err;
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
            s2_we    <= s1_we;
            s2_err   <= s1_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl.enable     <= 1'b0;
            tbl.wr_en      <= 1'b0;
            tbl.addr       <= '0;
            tbl.write_data <= '0;
        end else begin
            tbl.enable <= gnt_fwd;
            tbl.wr_en  <= gnt_fwd & gnt_we;
            if (gnt_fwd) begin
                tbl.addr       <= gnt_addr;
                tbl.write_data <= gnt_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= 16'h0000;
        end else if (rq0_valid & rq1_valid & gnt_any & (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    // Memory read data is only passed through for a legal read owned by that requester.
    always_comb begin
        rs0_valid = s2_valid & ~s2_id;
        rs1_valid = s2_valid &  s2_id;
        rs0_err   = rs0_valid & s2_err;
        rs1_err   = rs1_valid & s2_err;
        rs0_rdata = '0;
        rs1_rdata = '0;
        if (rs0_valid & ~s2_we & ~s2_err) begin
            rs0_rdata = tbl.read_data;
        end
        if (rs1_valid & ~s2_we & ~s2_err) begin
            rs1_rdata = tbl.read_data;
        end
    end
endmodule

// File: tb/tb_table_port_arbiter.sv
// Random and directed stimulus for table_port_arbiter, checked every cycle
// against a transaction-level model of arbitration, table access and responses.
module tb_table_port_arbiter;
    localparam int AW    = 4;
    localparam int DW    = 64;
    localparam int DEPTH = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rq0_valid = 1'b0, rq0_we = 1'b0;
    logic [AW-1:0] rq0_addr = '0;
    logic [DW-1:0] rq0_wdata = '0;
    logic          rq1_valid = 1'b0, rq1_we = 1'b0;
    logic [AW-1:0] rq1_addr = '0;
    logic [DW-1:0] rq1_wdata = '0;
    logic          lock = 1'b0;
    logic          rq0_ready, rq1_ready;
    logic          rs0_valid, rs0_err, rs1_valid, rs1_err;
    logic [DW-1:0] rs0_rdata, rs1_rdata;
    logic [15:0]   conflict_cnt;

    always #5 clk = ~clk;

    memory_if #(.ADDR_W(AW), .DATA_W(DW)) tbl_bus ();

    table_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_we(rq0_we),
        .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_we(rq1_we),
        .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
        .rs0_valid(rs0_valid), .rs0_err(rs0_err), .rs0_rdata(rs0_rdata),
        .rs1_valid(rs1_valid), .rs1_err(rs1_err), .rs1_rdata(rs1_rdata),
        .tbl(tbl_bus),
        .lock(lock), .conflict_cnt(conflict_cnt)
    );

    function automatic logic [DW-1:0] init_word(int i);
        if (i == 9) return 64'h0000_0000_DEAD_BEEF;
        return {32'hC0DE_0000 + i, 32'h1234_5670 + i};
    endfunction

    // Synchronous-read table memory
    logic [DW-1:0] mem [16];
    logic [DW-1:0] rd_q = '0;
    bit            mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (tbl_bus.enable) begin
            if (tbl_bus.wr_en) mem[tbl_bus.addr] <= tbl_bus.write_data;
            else               rd_q <= mem[tbl_bus.addr];
        end
    end
    assign tbl_bus.read_data = rd_q;

    typedef struct {
        bit            g;
        bit            id;
        bit            we;
        bit            err;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } rec_t;

    int            errors = 0;
    int            checks = 0;
    rec_t          h1, h2;
    bit            mptr;
    int unsigned   mcnt;
    logic [DW-1:0] ref_mem [16];

    bit            pv [2];
    bit            pwe [2];
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];
    bit            lk;
    bit            r0, r1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic rec_t empty_rec();
        rec_t r;
        r.g = 0; r.id = 0; r.we = 0; r.err = 0; r.addr = '0; r.wdata = '0; r.rdata = '0;
        return r;
    endfunction

    // Transaction-level model: who wins this cycle, what the table sees one
    // cycle later, what each requester hears two cycles later.
    task automatic model_check();
        bit            cand0, cand1, gnt, gid, due;
        rec_t          r;
        logic          act_v, act_e;
        logic [DW-1:0] act_d, exp_d;
        if (!rst_n) begin
            chk("rst_ready0", rq0_ready, 0);
            chk("rst_ready1", rq1_ready, 0);
            chk("rst_tbl_en", tbl_bus.enable, 0);
            chk("rst_tbl_we", tbl_bus.wr_en, 0);
            chk("rst_tbl_addr", tbl_bus.addr, 0);
            chk("rst_tbl_wdata", tbl_bus.write_data, 0);
            chk("rst_rs0", {rs0_valid, rs0_err, rs0_rdata}, 0);
            chk("rst_rs1", {rs1_valid, rs1_err, rs1_rdata}, 0);
            chk("rst_conflict", conflict_cnt, 0);
            mptr = 0; mcnt = 0; h1 = empty_rec(); h2 = empty_rec();
            return;
        end
        cand0 = rq0_valid;
        cand1 = rq1_valid && !lock;
        gnt   = cand0 || cand1;
        if (cand0 && cand1) gid = mptr;
        else                gid = cand1;
        chk("ready0", rq0_ready, gnt && !gid);
        chk("ready1", rq1_ready, gnt && gid);

        chk("tbl_enable", tbl_bus.enable, h1.g && !h1.err);
        if (h1.g && !h1.err) begin
            chk("tbl_wr_en", tbl_bus.wr_en, h1.we);
            chk("tbl_addr", tbl_bus.addr, h1.addr);
            if (h1.we) chk("tbl_wdata", tbl_bus.write_data, h1.wdata);
        end

        for (int i = 0; i < 2; i++) begin
            due   = h2.g && (h2.id == i[0]);
            act_v = i ? rs1_valid : rs0_valid;
            act_e = i ? rs1_err   : rs0_err;
            act_d = i ? rs1_rdata : rs0_rdata;
            exp_d = (due && !h2.we && !h2.err) ? h2.rdata : '0;
            chk($sformatf("rs%0d_valid", i), act_v, due);
            chk($sformatf("rs%0d_err", i), act_e, due && h2.err);
            chk($sformatf("rs%0d_rdata", i), act_d, exp_d);
        end

        chk("conflict_cnt", conflict_cnt, mcnt);

        if (rq0_valid && rq1_valid && gnt && mcnt < 32'hFFFF) mcnt++;
        if (gnt) mptr = !gid;

        r = empty_rec();
        r.g = gnt;
        if (gnt) begin
            r.id    = gid;
            r.we    = gid ? rq1_we : rq0_we;
            r.addr  = gid ? rq1_addr : rq0_addr;
            r.wdata = gid ? rq1_wdata : rq0_wdata;
            r.err   = (r.addr >= DEPTH);
            if (!r.err) begin
                if (r.we) ref_mem[r.addr] = r.wdata;
                else      r.rdata = ref_mem[r.addr];
            end
        end
        h2 = h1;
        h1 = r;
    endtask

    task automatic cycle();
        @(posedge clk); #1;
        rq0_valid = pv[0]; rq0_we = pwe[0]; rq0_addr = pa[0]; rq0_wdata = pd[0];
        rq1_valid = pv[1]; rq1_we = pwe[1]; rq1_addr = pa[1]; rq1_wdata = pd[1];
        lock = lk;
        @(negedge clk);
        model_check();
        r0 = rq0_ready;
        r1 = rq1_ready;
        if (r0) pv[0] = 0;
        if (r1) pv[1] = 0;
    endtask

    task automatic set_req(int i, bit we, logic [AW-1:0] addr, logic [DW-1:0] data);
        pv[i] = 1; pwe[i] = we; pa[i] = addr; pd[i] = data;
    endtask

    task automatic refill(int i, int pct);
        if (!pv[i] && $urandom_range(99) < pct)
            set_req(i, 1'($urandom_range(1)), AW'($urandom_range(15)), {$urandom, $urandom});
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0;
        pv[0] = 0; pv[1] = 0; lk = 0; lock = 0;
        rq0_valid = 0; rq1_valid = 0;
        @(negedge clk); model_check();
        @(posedge clk); #1;
        @(negedge clk); model_check();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        pv[0] = 0; pv[1] = 0; pwe[0] = 0; pwe[1] = 0;
        pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0; lk = 0;
        mptr = 0; mcnt = 0; h1 = empty_rec(); h2 = empty_rec();
        do_reset();

        // Single write straight out of reset
        set_req(0, 1, 4'd3, 64'hA5);
        cycle(); chk("w3_ready", r0, 1);
        cycle();
        chk("w3_tbl_en", tbl_bus.enable, 1);
        chk("w3_tbl_we", tbl_bus.wr_en, 1);
        chk("w3_tbl_addr", tbl_bus.addr, 3);
        chk("w3_tbl_wdata", tbl_bus.write_data, 64'hA5);
        cycle();
        chk("w3_rs0", {rs0_valid, rs0_err, rs0_rdata}, {2'b10, 64'h0});

        // Alternation under contention
        do_reset();
        set_req(0, 0, 4'd1, '0);
        set_req(1, 0, 4'd2, '0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk($sformatf("alt%0d_ready0", k), r0, (k % 2) == 0);
            chk($sformatf("alt%0d_ready1", k), r1, (k % 2) == 1);
            if (k < 3) begin
                if (!pv[0]) set_req(0, 0, 4'd1, '0);
                if (!pv[1]) set_req(1, 0, 4'd2, '0);
            end
        end
        cycle();
        cycle(); chk("alt_conflicts", conflict_cnt, 4);

        // Read of the last legal entry
        set_req(1, 0, 4'd9, '0);
        cycle(); cycle(); cycle();
        chk("rd9_rs1_valid", rs1_valid, 1);
        chk("rd9_rs1_rdata", rs1_rdata, 64'hDEAD_BEEF);

        // First illegal address
        set_req(0, 0, 4'd10, '0);
        cycle(); cycle();
        chk("ill_tbl_en", tbl_bus.enable, 0);
        cycle();
        chk("ill_rs0", {rs0_valid, rs0_err, rs0_rdata}, {2'b11, 64'h0});

        // Lock: requester 0 only, then the pointer still favours requester 1
        lk = 1;
        set_req(1, 0, 4'd5, '0);
        for (int k = 0; k < 3; k++) begin
            set_req(0, 0, 4'd0, '0);
            cycle();
            chk($sformatf("lock%0d_ready0", k), r0, 1);
            chk($sformatf("lock%0d_ready1", k), r1, 0);
        end
        lk = 0;
        set_req(0, 0, 4'd0, '0);
        cycle();
        chk("lock_conflicts", conflict_cnt, 7);
        chk("unlock_ready1", r1, 1);
        cycle(); cycle(); cycle();

        // Reset one cycle after a read grant
        set_req(0, 0, 4'd4, '0);
        cycle(); chk("rstrd_ready0", r0, 1);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk($sformatf("rstrd%0d_rs0_valid", k), rs0_valid, 0);
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            lk = ($urandom_range(99) < 20);
            refill(0, 60);
            refill(1, 60);
            cycle();
        end

        // Counter saturation under continuous contention
        do_reset();
        guard = 0;
        while (mcnt < 32'hFFFE && guard < 70000) begin
            lk = 1'($urandom_range(1));
            refill(0, 100); refill(1, 100);
            cycle();
            guard++;
        end
        chk("sat_budget", guard < 70000, 1);
        for (int k = 0; k < 3; k++) begin
            refill(0, 100); refill(1, 100);
            cycle();
            if (k == 0) chk("sat_pre", conflict_cnt, 16'hFFFE);
        end
        lk = 0;
        cycle(); cycle();
        chk("sat_hold", conflict_cnt, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
